// File: rtl/clint_pkg.sv
// Shared constants and register types for the core-local interruptor.
// Offsets are byte offsets within the 64 KiB CLINT window.
package clint_pkg;

    localparam logic [15:0] clint_msip_off        = 16'h0000;
    localparam logic [15:0] clint_mtimecmp_lo_off = 16'h4000;
    localparam logic [15:0] clint_mtimecmp_hi_off = 16'h4004;
    localparam logic [15:0] clint_mtime_lo_off    = 16'hBFF8;
    localparam logic [15:0] clint_mtime_hi_off    = 16'hBFFC;

    typedef enum logic {
        IDLE,
        RESP
    } clint_state_t;

    typedef struct packed {
        logic        msip;
        logic [63:0] mtime;
        logic [63:0] mtimecmp;
        logic        mtip;
    } clint_reg_type;

    localparam clint_reg_type init_clint_reg = '{
        msip:     1'b0,
        mtime:    64'h0,
        mtimecmp: 64'hFFFF_FFFF_FFFF_FFFF,
        mtip:     1'b0
    };

endpackage

// File: rtl/clint_if.sv
// Data-memory bus connection between the interconnect and the CLINT responder.
interface clint_if;

    logic        clint_valid;
    logic [31:0] clint_addr;
    logic [31:0] clint_wdata;
    logic [3:0]  clint_wstrb;
    logic [31:0] clint_rdata;
    logic        clint_ready;

    modport master (
        output clint_valid, clint_addr, clint_wdata, clint_wstrb,
        input  clint_rdata, clint_ready
    );

    modport slave (
        input  clint_valid, clint_addr, clint_wdata, clint_wstrb,
        output clint_rdata, clint_ready
    );

endinterface

// File: rtl/clint_tick.sv
// Prescaler for mtime: counts 0..RTC_DIV-1 and emits a tick on the wrap.
module clint_tick #(
    parameter int RTC_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(RTC_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, free-running mtime and mtimecmp behind a
// two-state bus responder; all outputs come straight from registers.
module clint
    import clint_pkg::*;
#(
    parameter int RTC_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    clint_if.slave      bus,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

    clint_reg_type r;
    clint_reg_type r_next;
    clint_state_t  state;
    logic          tick;
    logic          accept;
    logic          wr;
    logic [13:0]   word;
    logic [31:0]   read_value;
    logic [31:0]   rdata_q;
    logic          ready_q;
    logic          unused_addr;

    clint_tick #(.RTC_DIV(RTC_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    assign unused_addr = &{1'b0, bus.clint_addr[31:16], bus.clint_addr[1:0]};

    // A bus write to an mtime half replaces the tick increment for that cycle.
    always_comb begin
        accept     = (state == IDLE) && bus.clint_valid;
        wr         = accept && (bus.clint_wstrb != 4'b0000);
        word       = bus.clint_addr[15:2];
        read_value = '0;
        r_next     = r;

        case (word)
            clint_msip_off[15:2]:        read_value = {31'b0, r.msip};
            clint_mtimecmp_lo_off[15:2]: read_value = r.mtimecmp[31:0];
            clint_mtimecmp_hi_off[15:2]: read_value = r.mtimecmp[63:32];
            clint_mtime_lo_off[15:2]:    read_value = r.mtime[31:0];
            clint_mtime_hi_off[15:2]:    read_value = r.mtime[63:32];
            default:                     read_value = '0;
        endcase

        r_next.mtip = (r.mtime >= r.mtimecmp);
        if (tick) r_next.mtime = r.mtime + 64'd1;

        if (wr) begin
            case (word)
                clint_msip_off[15:2]: begin
                    if (bus.clint_wstrb[0]) r_next.msip = bus.clint_wdata[0];
                end
                clint_mtimecmp_lo_off[15:2]:
                    r_next.mtimecmp[31:0] = merge_bytes(r.mtimecmp[31:0], bus.clint_wdata, bus.clint_wstrb);
                clint_mtimecmp_hi_off[15:2]:
                    r_next.mtimecmp[63:32] = merge_bytes(r.mtimecmp[63:32], bus.clint_wdata, bus.clint_wstrb);
                clint_mtime_lo_off[15:2]:
                    r_next.mtime = {r.mtime[63:32], merge_bytes(r.mtime[31:0], bus.clint_wdata, bus.clint_wstrb)};
                clint_mtime_hi_off[15:2]:
                    r_next.mtime = {merge_bytes(r.mtime[63:32], bus.clint_wdata, bus.clint_wstrb), r.mtime[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r       <= init_clint_reg;
            state   <= IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            r <= r_next;
            case (state)
                IDLE: begin
                    if (bus.clint_valid) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        rdata_q <= read_value;
                    end else begin
                        ready_q <= 1'b0;
                        rdata_q <= '0;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign bus.clint_rdata = rdata_q;
    assign bus.clint_ready = ready_q;
    assign clint_msip      = r.msip;
    assign clint_mtip      = r.mtip;
    assign clint_mtime     = r.mtime;

endmodule

// File: doc/clint.md
Name: clint

Overview:
- Core-local interruptor: the memory-mapped producer of the machine software-interrupt, timer-interrupt and mtime signals that the CSR unit consumes.
- Sits on the data-memory bus as a responder, behind the interconnect address decoder.
- Holds msip, a free-running 64-bit mtime and a 64-bit mtimecmp.
- Drives msip, mtip and mtime straight into the CSR unit's interrupt inputs.

Parameters:
- RTC_DIV, 1, number of clock cycles per mtime increment; must be >= 1, and 1 means mtime increments every clock.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clint_valid  in  1  request valid; the master holds it until clint_ready
- clint_addr  in  32  byte address; only bits [15:0] are decoded
- clint_wdata  in  32  write data
- clint_wstrb  in  4  byte write strobes; 0000 means read
- clint_rdata  out  32  read data, valid while clint_ready=1
- clint_ready  out  1  one-cycle response pulse
- clint_msip  out  1  machine software interrupt pending
- clint_mtip  out  1  machine timer interrupt pending
- clint_mtime  out  64  current mtime value

Behaviour:
- Reset (reset=1 at a clock edge) sets:
  - msip=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, mtip=0
  - FSM state=IDLE, clint_ready=0, clint_rdata=0
- Reset wins over any in-flight request. A response pending when reset hits is dropped, so clint_ready=0 on the next cycle.
- Register map (offsets in addr[15:0], word aligned; addr[1:0] ignored):
  - 0x0000 msip: bit0 is the register; bits 31:1 read 0
  - 0x4000 mtimecmp[31:0]
  - 0x4004 mtimecmp[63:32]
  - 0xBFF8 mtime[31:0]
  - 0xBFFC mtime[63:32]
  - Any other offset reads 0, ignores writes, and still responds.
- Bus FSM, two states:
  - IDLE: if clint_valid=1, accept the request and go to RESP.
  - RESP: clint_ready=1 and clint_rdata=read value for one cycle; then return to IDLE. clint_valid is ignored in RESP, so a held valid is never accepted twice.
  - Throughput is at most one access per two cycles.
- Read data is the register value at the accept edge. A read of mtime returns the pre-increment value; read data is zero in cycles without clint_ready.
- Writes commit at the accept edge, so the new value is visible on the outputs in the same cycle that clint_ready=1.
  - Byte lanes are merged per clint_wstrb; unstrobed bytes keep their old value.
  - For msip, only strobe bit 0 / wdata[0] matters.
- Prescaler counts 0..RTC_DIV-1 and wraps; a tick is generated on the wrap.
  - When RTC_DIV=1 a tick occurs every cycle.
  - On a tick, mtime <= mtime+1, modulo 2^64 (all-ones wraps to 0).
- Write to either mtime half in the same cycle as a tick: the write wins and the increment for that cycle is lost. The prescaler keeps running.
- 64-bit updates are two independent 32-bit accesses with no atomicity; carry handling between halves is software's responsibility.
- mtip is registered: mtip <= (mtime >= mtimecmp), unsigned 64-bit compare on current register values.
  - This gives one cycle of lag after mtime or mtimecmp changes.
  - mtip stays high until mtimecmp is raised above mtime or mtime wraps below it.
- clint_msip = msip register; clint_mtime = mtime register; no combinational path from the bus inputs to any output.

Decomposition:
- Shared constants package: offset constants clint_msip_off, clint_mtimecmp_lo_off, clint_mtimecmp_hi_off, clint_mtime_lo_off, clint_mtime_hi_off.
- Shared wires package: clint_reg_type (msip, mtime, mtimecmp, mtip) and init_clint_reg with the reset values above.
- Optional sub-module clint_tick holds the prescaler and emits the tick. The byte-merge is a local function.

Test Plan:
- Reset → clint_ready=0, msip=0, mtip=0, mtime=0; reads of 0x4000 and 0x4004 return 0xFFFFFFFF; reset asserted during RESP → ready=0 next cycle.
- Write 0x0000 wdata=0x1 wstrb=0xF → ready exactly 1 cycle after valid with msip=1 that cycle; write 0xFFFFFFFE → msip=0; read returns 0x00000000.
- RTC_DIV=1: write mtimecmp_hi=0, mtimecmp_lo=40 → mtip rises the cycle after mtime reads 40; write mtimecmp_lo=0xFFFFFFFF → mtip falls 1 cycle after commit.
- Wrap: write mtime_hi=0xFFFFFFFF, then mtime_lo=0xFFFFFFFE → after 2 ticks mtime=0; mtip=1 while mtime=all-ones, then 0.
- Byte strobes: mtimecmp_lo=0xFFFFFFFF, write 0xAABBCCDD wstrb=0101 → read 0xFFBBFFDD; write to mtime_lo on a tick cycle → mtime_lo equals the written value, not value+1.
- Unmapped 0x1000 read → rdata=0, ready=1; valid held high 3 cycles → exactly one ready pulse per accept, none in consecutive cycles. RTC_DIV=4 → mtime increments every 4th cycle.
